// File: rtl/front_pkg.sv
// Shared front-end types and sizing used by the prefetch queue, decode_opcode and the bus unit.
package front_pkg;

   typedef logic [7:0] byte_t;

   localparam int unsigned PQ_DEPTH    = 16;
   localparam int unsigned INSN_WINDOW = 10;
   localparam int unsigned PQ_COUNT_W  = $clog2(PQ_DEPTH) + 1;

   typedef logic [PQ_COUNT_W-1:0] pq_count_t;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

endpackage

// File: rtl/prefetch_queue_rotate.sv
// Rotates the circular byte store so the oldest byte lands in window[0]; slots past count read as zero.
module prefetch_queue_rotate
   import front_pkg::*;
#(
   parameter int unsigned DEPTH  = PQ_DEPTH,
   parameter int unsigned WINDOW = INSN_WINDOW
) (
   input  byte_t                    mem    [DEPTH],
   input  logic [$clog2(DEPTH)-1:0] rd_ptr,
   input  logic [$clog2(DEPTH):0]   count,
   output byte_t                    window [0:WINDOW-1]
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   always_comb begin
      for (int unsigned i = 0; i < WINDOW; i++) begin
         window[i] = '0;
         if (CW'(i) < count)
            window[i] = mem[rd_ptr + PW'(i)];
      end
   end

endmodule

// File: rtl/prefetch_queue.sv
// Byte-wide circular prefetch queue feeding the decoder's aligned instruction window.
// Optional PREFETCH_QUEUE_BYTE_MASK_EN adds fetch_byte_en for partial (misaligned) fetches.
module prefetch_queue
   import front_pkg::*;
#(
   parameter int unsigned DEPTH  = PQ_DEPTH,
   parameter int unsigned WINDOW = INSN_WINDOW
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   fetch_valid,
   output logic                   fetch_ready,
   input  logic [31:0]            fetch_data,
`ifdef PREFETCH_QUEUE_BYTE_MASK_EN
   input  logic [3:0]             fetch_byte_en,
`endif
   output byte_t                  instruction [0:WINDOW-1],
   output logic [$clog2(DEPTH):0] valid_count,
   input  logic                   consume_valid,
   input  logic [3:0]             consume_len,
   output logic                   consume_ready
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   byte_t         mem [DEPTH];

   logic [3:0]    wr_bytes;
   logic          wr;
   logic          rd;
   logic [2:0]    wr_len;
   logic [3:0]    rd_len;

`ifdef PREFETCH_QUEUE_BYTE_MASK_EN
   assign wr_bytes = fetch_byte_en;
`else
   assign wr_bytes = 4'b1111;
`endif

   // Ready flags look only at registered count, never at same-cycle consume/flush.
   assign fetch_ready   = (count <= CW'(DEPTH - 4));
   assign consume_ready = (consume_len != 4'd0) && (CW'(consume_len) <= count);

   assign wr     = fetch_valid && fetch_ready;
   assign rd     = consume_valid && consume_ready;
   assign wr_len = wr ? popcount4(wr_bytes) : 3'd0;
   assign rd_len = rd ? consume_len : 4'd0;

   always_comb begin
      count_next = count + CW'(wr_len) - CW'(rd_len);
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + PW'(rd_len);
         wr_ptr <= wr_ptr + PW'(wr_len);
         count  <= count_next;
      end
   end

   // Masks are low-contiguous, so byte k lands at wr_ptr+k whenever its enable is set.
   always_ff @(posedge clock) begin
      if (!reset && !flush && wr) begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (wr_bytes[k])
               mem[wr_ptr + PW'(k)] <= fetch_data[8*k +: 8];
         end
      end
   end

`ifdef PREFETCH_QUEUE_BYTE_MASK_EN
   a_legal_byte_en : assert property (@(posedge clock) disable iff (reset)
      fetch_valid |-> (fetch_byte_en inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111}));
`endif

   assign valid_count = count;

   prefetch_queue_rotate #(
      .DEPTH  (DEPTH),
      .WINDOW (WINDOW)
   ) u_rotate (
      .mem    (mem),
      .rd_ptr (rd_ptr),
      .count  (count),
      .window (instruction)
   );

endmodule
